// File: rtl/bilateral_line_fetch.sv
// Raster-scan pixel fetch with a circular (KSIZE-1)-row line buffer, emitting KSIZE-tall columns.
// Optional frame_sum checksum output is built when FETCH_CHECKSUM_EN is defined.
module bilateral_line_fetch #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int KSIZE  = 11,
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic [ADDR_W-1:0]    in_addr,
    output logic                 rd_en,
    input  logic [7:0]           in_data,
    output logic                 col_valid,
    input  logic                 col_ready,
    output logic [8*KSIZE-1:0]   col_data,
    output logic [7:0]           col_x,
    output logic [7:0]           col_y,
    output logic                 busy,
    output logic                 done
`ifdef FETCH_CHECKSUM_EN
    ,
    output logic [15:0]          frame_sum
`endif
);

    localparam int LB_ROWS = KSIZE - 1;
    localparam int SLOT_W  = (LB_ROWS > 1) ? $clog2(LB_ROWS) : 1;
    localparam int X_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [X_W-1:0]    LAST_X      = X_W'(IMG_W - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(LB_ROWS - 1);
    localparam logic [7:0]        LAST_COL_X  = 8'(IMG_W - 1);
    localparam logic [7:0]        LAST_COL_Y  = 8'(IMG_H - 1);
    localparam logic [7:0]        FIRST_OUT_Y = 8'(KSIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 busy_r;
    logic                 done_r;

    logic [ADDR_W-1:0]    rd_ptr_r;
    logic                 rd_pend_r;

    logic [7:0]           fifo_mem_r [2];
    logic                 fifo_wr_r;
    logic                 fifo_rd_r;
    logic [1:0]           fifo_cnt_r;

    logic [7:0]           lb_r [LB_ROWS][IMG_W];
    logic [X_W-1:0]       px_x_r;
    logic [7:0]           px_y_r;
    logic [SLOT_W-1:0]    slot_r;

    logic                 out_valid_r;
    logic [8*KSIZE-1:0]   col_data_r;
    logic [7:0]           col_x_r;
    logic [7:0]           col_y_r;

    logic                 start_ok_s;
    logic                 pop_s;
    logic [2:0]           inflight_s;
    logic                 rd_en_s;
    logic                 last_read_s;
    logic                 last_accept_s;
    logic [7:0]           head_s;
    logic [8*KSIZE-1:0]   col_next_s;

    assign start_ok_s    = (state_r == ST_IDLE) && start;
    assign head_s        = fifo_mem_r[fifo_rd_r];
    assign pop_s         = (fifo_cnt_r != 2'd0) && (!out_valid_r || col_ready);
    // Credit is judged on the FIFO occupancy after this cycle's pop so a steady stream runs at one read per cycle.
    assign inflight_s    = 3'(fifo_cnt_r) + {2'b00, rd_pend_r} - {2'b00, pop_s};
    assign rd_en_s       = (state_r == ST_FETCH) && in_valid && (inflight_s < 3'd2);
    assign last_read_s   = rd_en_s && (rd_ptr_r == LAST_ADDR);
    assign last_accept_s = out_valid_r && col_ready &&
                           (col_x_r == LAST_COL_X) && (col_y_r == LAST_COL_Y);

    // Frame sequencing: state register with registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_FETCH) || (state_s == ST_DRAIN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (last_read_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (last_accept_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Read address pointer; stops at the last pixel and never wraps within a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r  <= '0;
            rd_pend_r <= 1'b0;
        end else begin
            rd_pend_r <= rd_en_s;
            if (start_ok_s) begin
                rd_ptr_r <= '0;
            end else if (rd_en_s && !last_read_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Two-entry return FIFO; data for a read arrives the cycle after rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_r[0] <= 8'h00;
            fifo_mem_r[1] <= 8'h00;
            fifo_wr_r     <= 1'b0;
            fifo_rd_r     <= 1'b0;
            fifo_cnt_r    <= 2'd0;
        end else begin
            if (rd_pend_r) begin
                fifo_mem_r[fifo_wr_r] <= in_data;
                fifo_wr_r             <= ~fifo_wr_r;
            end else begin
                fifo_wr_r <= fifo_wr_r;
            end
            if (pop_s) begin
                fifo_rd_r <= ~fifo_rd_r;
            end else begin
                fifo_rd_r <= fifo_rd_r;
            end
            case ({rd_pend_r, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Pixel position of the FIFO head and the line-buffer slot of its row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_x_r <= '0;
            px_y_r <= 8'h00;
            slot_r <= '0;
        end else if (start_ok_s) begin
            px_x_r <= '0;
            px_y_r <= 8'h00;
            slot_r <= '0;
        end else if (pop_s) begin
            px_x_r <= px_x_r + X_W'(1);
            if (px_x_r == LAST_X) begin
                px_y_r <= px_y_r + 8'd1;
                slot_r <= (slot_r == LAST_SLOT) ? '0 : slot_r + SLOT_W'(1);
            end else begin
                px_y_r <= px_y_r;
                slot_r <= slot_r;
            end
        end else begin
            px_x_r <= px_x_r;
            px_y_r <= px_y_r;
            slot_r <= slot_r;
        end
    end

    // Column assembly: the slot about to be overwritten holds the top row (y-KSIZE+1 == y mod LB_ROWS).
    always_comb begin : col_assemble
        logic [SLOT_W:0] idx_v;
        idx_v      = '0;
        col_next_s = '0;
        for (int r = 0; r < LB_ROWS; r++) begin
            idx_v = {1'b0, slot_r} + (SLOT_W+1)'(r);
            if (idx_v >= (SLOT_W+1)'(LB_ROWS)) begin
                idx_v = idx_v - (SLOT_W+1)'(LB_ROWS);
            end else begin
                idx_v = idx_v;
            end
            col_next_s[8*r +: 8] = lb_r[idx_v[SLOT_W-1:0]][px_x_r];
        end
        col_next_s[8*KSIZE-1 -: 8] = head_s;
    end

    // Line-buffer storage; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            lb_r[slot_r][px_x_r] <= head_s;
        end
    end

    // Output column register, held stable while the core stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            col_data_r  <= '0;
            col_x_r     <= 8'h00;
            col_y_r     <= 8'h00;
        end else if (pop_s) begin
            if (px_y_r >= FIRST_OUT_Y) begin
                out_valid_r <= 1'b1;
                col_data_r  <= col_next_s;
                col_x_r     <= 8'(px_x_r);
                col_y_r     <= px_y_r;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (out_valid_r && col_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef FETCH_CHECKSUM_EN
    logic [15:0] frame_sum_r;

    // Running modulo-2^16 sum of every pixel consumed this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_sum_r <= 16'h0000;
        end else if (start_ok_s) begin
            frame_sum_r <= 16'h0000;
        end else if (pop_s) begin
            frame_sum_r <= frame_sum_r + {8'h00, head_s};
        end else begin
            frame_sum_r <= frame_sum_r;
        end
    end

    assign frame_sum = frame_sum_r;
`endif

    assign in_addr   = rd_ptr_r;
    assign rd_en     = rd_en_s;
    assign col_valid = out_valid_r;
    assign col_data  = col_data_r;
    assign col_x     = col_x_r;
    assign col_y     = col_y_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
